// File: rtl/sequencer_pkg.sv
// Shared types and constants for the sequencer step engine.
package sequencer_pkg;

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        PAUSED  = 2'd1,
        RUNNING = 2'd2
    } seq_state_t;

    localparam int NUM_STEPS  = 8;
    localparam int STEP_W     = $clog2(NUM_STEPS);
    localparam int PRESCALE_W = 14;

    // Beat periods in 10 kHz clock cycles: 60, 100, 120 and 150 BPM.
    localparam int unsigned TEMPO_PERIOD [4] = '{10000, 6000, 5000, 4000};

    function automatic logic [PRESCALE_W-1:0] scaled_period(input logic [1:0] sel,
                                                            input int unsigned div);
        return PRESCALE_W'(TEMPO_PERIOD[sel] / div);
    endfunction

endpackage

// File: rtl/tempo_prescaler.sv
// Beat prescaler: counts enabled cycles and flags the last cycle of each period.
module tempo_prescaler
    import sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  en,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] period,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] count;

    // A clear in the terminal cycle suppresses the tick, so a tempo change wins.
    assign tick = en && !clear && (count == period - PRESCALE_W'(1));

    // NOTE: state registers use non-blocking assignments; the reset is synchronous, so it sits inside the clocked branch.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else if (en) begin
            count <= count + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/sequencer_stepper.sv
// Sequencer step engine: run/pause FSM, 8-step pattern, tempo selection and beat stepping.
module sequencer_stepper
    import sequencer_pkg::*;
#(
    parameter int PERIOD_DIV = 1
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [7:0]  toggle,
    input  logic        tempo_button,
    input  logic        sequencer_on,
    input  logic        play,
    output logic [2:0]  step,
    output logic [7:0]  pattern,
    output logic [1:0]  tempo_sel,
    output logic        note_gate,
    output logic        beat_pulse
);

    seq_state_t            state;
    seq_state_t            state_next;
    logic [PRESCALE_W-1:0] period;
    logic                  presc_clear;
    logic                  tick;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= OFF;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: next state gets a default before the case so no path can infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            OFF:     if (sequencer_on) state_next = play ? RUNNING : PAUSED;
            PAUSED:  if (!sequencer_on) state_next = OFF;
                     else if (play)     state_next = RUNNING;
            RUNNING: if (!sequencer_on) state_next = OFF;
                     else if (!play)    state_next = PAUSED;
            default: state_next = OFF;
        endcase
    end

    assign period      = scaled_period(tempo_sel, int'(PERIOD_DIV));
    assign presc_clear = tempo_button || (state_next == OFF);

    tempo_prescaler u_prescaler (
        .clk    (clk),
        .n_rst  (n_rst),
        .en     (state == RUNNING),
        .clear  (presc_clear),
        .period (period),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            pattern    <= '0;
            tempo_sel  <= '0;
            step       <= '0;
            beat_pulse <= 1'b0;
        end else begin
            if (state != OFF) begin
                pattern <= pattern ^ toggle;
            end
            if (tempo_button) begin
                tempo_sel <= tempo_sel + 2'd1;
            end
            // Leaving for OFF parks the step at 0; it stays there while OFF.
            if (state_next == OFF) begin
                step <= '0;
            end else if (tick) begin
                step <= step + 3'd1;
            end
            beat_pulse <= tick;
        end
    end

    assign note_gate = (state == RUNNING) && pattern[step];

endmodule

// File: doc/sequencer_stepper.md
# sequencer_stepper

Step engine for sequencer mode, directly downstream of the key encoder. It consumes the encoder's edge-detected `toggle[7:0]` and `tempo_button` pulses and its sustained `sequencer_on` and `play` levels. It maintains an 8-step on/off pattern, a 4-entry tempo selection and a beat prescaler. It emits the current step index, a per-step note gate and a one-cycle beat pulse to the sound path.

## Interface
Parameters:
- `PERIOD_DIV`, default 1: divisor applied to every tempo period constant. It must divide each constant exactly. Set it >1 only to shorten simulation.

Ports:
- `clk` in 1: 10 kHz system clock.
- `n_rst` in 1: reset, synchronous and active-low. Sampled on the rising edge of `clk`.
- `toggle` in 8: one-cycle pulses; bit i flips pattern step i.
- `tempo_button` in 1: one-cycle pulse; advances the tempo selection.
- `sequencer_on` in 1: level; 1 selects sequencer mode.
- `play` in 1: level; 1 runs the sequencer, 0 pauses it.
- `step` out 3: current step index, 0..7.
- `pattern` out 8: the pattern register.
- `tempo_sel` out 2: current tempo index.
- `note_gate` out 1: high while RUNNING and `pattern[step]`=1.
- `beat_pulse` out 1: one-cycle pulse on each step advance.

## Operation
- FSM states are OFF, PAUSED and RUNNING. It is registered and resets to OFF.
  - OFF → PAUSED when `sequencer_on`=1 and `play`=0.
  - OFF → RUNNING when `sequencer_on`=1 and `play`=1.
  - PAUSED ↔ RUNNING follows `play` while `sequencer_on`=1.
  - Any state → OFF when `sequencer_on`=0.
- Entering OFF clears `step` and the prescaler to 0. `pattern` and `tempo_sel` are retained.
- PAUSED holds both `step` and the prescaler count.
- Pattern updates:
  - In every state except OFF, `pattern <= pattern ^ toggle`.
  - In OFF, toggles are ignored.
  - Multiple toggle bits in one cycle all apply.
- Tempo updates:
  - `tempo_button` increments `tempo_sel` modulo 4 in any state, including OFF.
  - The same cycle clears the prescaler to 0. `step` is not cleared.
- Tempo periods in cycles, each divided by `PERIOD_DIV`:
  - index 0: 10000 (60 BPM)
  - index 1: 6000 (100 BPM)
  - index 2: 5000 (120 BPM)
  - index 3: 4000 (150 BPM)
- Prescaler: 14-bit count, active in RUNNING only. When count = period−1, the count wraps to 0, `step` increments modulo 8 (7→0) and `beat_pulse` is asserted.
- When a tempo change and a terminal count fall in the same cycle, the tempo change wins: the prescaler clears and there is no advance and no pulse.
- `note_gate` is combinational from the registered state, `step` and `pattern`. It is forced to 0 outside RUNNING.

## Timing
- Reset values: `step`=0, `pattern`=0, `tempo_sel`=0, `note_gate`=0, `beat_pulse`=0; FSM in OFF; prescaler at 0.
- Reset is taken mid-run with priority over all other inputs.
- Input pulse → register update at the next rising edge, so `pattern`, `tempo_sel` and `note_gate` reflect it one cycle later.
- `sequencer_on`/`play` change → FSM updates at the next edge. Prescaler counting starts in the first RUNNING cycle.
- First advance occurs exactly period cycles after RUNNING is entered from a cleared prescaler.
- `beat_pulse` is registered. It is high in the same cycle `step` shows its new value, for exactly one cycle.
- A toggle on the same edge as a step advance applies to the pattern bit addressed by bit index, independent of `step`. `note_gate` then shows the new step with the new pattern.

## Structure
- Package `sequencer_pkg`:
  - `seq_state_t` enum (OFF, PAUSED, RUNNING).
  - `TEMPO_PERIOD[4]` constant array.
  - `NUM_STEPS`=8.
- Sub-module `tempo_prescaler`:
  - Inputs: `clk`, `n_rst`, `en`, `clear`, `period` (14 bits).
  - Output: `tick`.
- The top level holds the FSM, pattern register, step counter and `tempo_sel`.

## Test plan
All scenarios use `PERIOD_DIV`=100.
- Reset, then `sequencer_on`=1, `play`=1 at tempo 0 → `beat_pulse` every 100 cycles; `step` goes 0,1,…,7,0.
- `toggle`=8'b0000_0101 pulse while PAUSED → `pattern`=0x05 next cycle. `note_gate` stays 0 until RUNNING, then goes high at steps 0 and 2 only.
- `tempo_button` pulsed three times → `tempo_sel`=3. Subsequent beats arrive 40 cycles apart. A fourth pulse gives `tempo_sel`=0.
- `play`=0 mid-beat at prescaler count 30, held for 500 cycles, then `play`=1 → next `beat_pulse` exactly 70 cycles after resume; `step` unchanged during the pause.
- `tempo_button` in the same cycle as the terminal count → no `beat_pulse`, no step change, prescaler restarts at 0.
- `n_rst`=0 for one cycle while RUNNING at `step`=5 with `pattern`=0xFF → all outputs at reset values the next cycle; OFF state.
